clk_div_meter: RTL and testbench
================================

Name: clk_div_meter

Overview:
Measurement stage placed directly downstream of the odd-ratio clock dividers. It samples a divided-clock signal in the sys_clk domain and accumulates sys_clk cycles over N_PERIODS consecutive periods, reporting total period length and total high time. A start/valid/ready handshake controls it. Board-level self-check uses it to confirm divide ratio and duty cycle without a scope.

Parameters:
N_PERIODS, 4, number of consecutive sig_in periods accumulated per measurement (>=1)
CNT_W, 16, width of period_cnt and high_cnt accumulators
TIMEOUT, 1023, max sys_clk cycles spent in ARM+MEASURE before forced abort (>=1)

Ports:
sys_clk  input  1  system clock; all logic on posedge
sys_rst_n  input  1  asynchronous, active-low reset
sig_in  input  1  divided clock under test; treated as asynchronous data, never used as a clock
start  input  1  one-cycle request to begin a measurement; honoured only in IDLE
busy  output  1  high in ARM and MEASURE
meas_valid  output  1  high in DONE; result is stable while high
meas_ready  input  1  consumer accepts result; DONE->IDLE when sampled high
period_cnt  output  CNT_W  sys_clk cycles covering N_PERIODS periods
high_cnt  output  CNT_W  cycles within those periods where synchronised sig_in was 1
err_timeout  output  1  result was ended by TIMEOUT, not by completing N_PERIODS

Behaviour:
- Reset (async assert, sync release): state=IDLE; busy=0, meas_valid=0, period_cnt=0, high_cnt=0, err_timeout=0; synchroniser flops=0.
- Input path: sig_in -> s1 -> s2 (2-flop sync) -> s3. rise = s2 & ~s3. The fixed 3-cycle delay does not affect counts.
- FSM states: IDLE, ARM, MEASURE, DONE.
- IDLE: start=1 -> ARM. Clear accumulators, edge counter and timeout timer. Clear err_timeout.
- ARM: wait for rise. On rise -> MEASURE. Load per_acc=1, high_acc=1 (rise cycle counts as the first cycle of period 1). Set edge_cnt=0.
- MEASURE, each cycle:
  - If rise and edge_cnt==N_PERIODS-1: go to DONE. This cycle is not counted; it is the first cycle of the next period.
  - Else if rise: edge_cnt+1, per_acc+1, high_acc+s2.
  - Else: per_acc+1, high_acc+s2.
- Timer: increments every cycle in ARM and MEASURE. When it reaches TIMEOUT, go to DONE with err_timeout=1 and accumulators as they stand (0/0 if still in ARM). Timeout takes priority over a simultaneous final rise.
- Saturation: per_acc and high_acc saturate at 2^CNT_W-1 and never wrap. high_acc <= per_acc always.
- DONE entry: period_cnt<=per_acc, high_cnt<=high_acc (registered, 1-cycle update with the state change). meas_valid=1.
- DONE: outputs held stable while meas_ready=0. meas_ready=1 -> IDLE next cycle, meas_valid=0.
- period_cnt/high_cnt keep the last result in IDLE. They are meaningful only while meas_valid=1.
- start is ignored in ARM, MEASURE and DONE. start together with meas_ready in DONE: only the ready is accepted; start must be reissued in IDLE.
- Reset mid-operation: immediate return to IDLE with all outputs at reset values; no partial result emitted.
- Constant sig_in (stuck 0 or stuck 1) produces no rise, so the measurement always ends via timeout.
- Sampling quantisation: counts are in whole sys_clk cycles. A 2.5-cycle high phase from the divide-by-5 block always samples as 3 high / 2 low.

Test Plan:
- sig_in driven by the divide-by-5 block (N_PERIODS=4), start pulse -> meas_valid after first rise + 20 cycles; period_cnt=20, high_cnt=12, err_timeout=0.
- sig_in pattern 1,1,0 repeating (divide-by-3), N_PERIODS=4 -> period_cnt=12, high_cnt=8, err_timeout=0.
- sig_in held 0, TIMEOUT=1023 -> busy for exactly 1023 cycles, then meas_valid=1, period_cnt=0, high_cnt=0, err_timeout=1.
- CNT_W=4, sig_in period 10 (5 high/5 low), N_PERIODS=4, TIMEOUT=1023 -> period_cnt=15, high_cnt=15 (both saturated), err_timeout=0.
- Result backpressure: meas_ready=0 for 10 cycles after meas_valid -> period_cnt/high_cnt/meas_valid unchanged; start pulses during this time ignored; meas_ready=1 -> IDLE next cycle.
- Assert sys_rst_n=0 in MEASURE after 7 cycles -> all outputs 0 asynchronously; after release, a fresh start on the divide-by-5 input again yields 20/12.

Source files
------------

// File: rtl/clk_div_meter.sv
// clk_div_meter: counts sys_clk cycles and high cycles over N_PERIODS periods of synchronised sig_in; in: sys_clk, sys_rst_n, sig_in, start, meas_ready; out: busy, meas_valid, period_cnt, high_cnt, err_timeout
module clk_div_meter #(
  parameter int N_PERIODS = 4,
  parameter int CNT_W = 16,
  parameter int TIMEOUT = 1023
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             sig_in,
  input  logic             start,
  output logic             busy,
  output logic             meas_valid,
  input  logic             meas_ready,
  output logic [CNT_W-1:0] period_cnt,
  output logic [CNT_W-1:0] high_cnt,
  output logic             err_timeout
);
  localparam int EW = N_PERIODS > 1 ? $clog2(N_PERIODS) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, ARM, MEASURE, DONE} state_t;
  state_t state, state_nx;
  logic s1, s2, s3, rise, tmo, last;
  logic [EW-1:0] edge_cnt;
  logic [TW-1:0] timer;
  logic [CNT_W-1:0] per_acc, high_acc;
  assign rise = s2 & ~s3;
  assign busy = state == ARM || state == MEASURE;
  assign meas_valid = state == DONE;
  assign tmo = busy && timer == TW'(TIMEOUT - 1);
  assign last = rise && edge_cnt == EW'(N_PERIODS - 1);
  always_comb begin
    state_nx = state == IDLE    ? (start ? ARM : IDLE) :
               state == ARM     ? (tmo ? DONE : rise ? MEASURE : ARM) :
               state == MEASURE ? (tmo || last ? DONE : MEASURE) :
                                  (meas_ready ? IDLE : DONE);
  end
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      state <= IDLE;
      {s3, s2, s1} <= '0;
      per_acc <= '0;
      high_acc <= '0;
      edge_cnt <= '0;
      timer <= '0;
      period_cnt <= '0;
      high_cnt <= '0;
      err_timeout <= 1'b0;
    end else begin
      state <= state_nx;
      {s3, s2, s1} <= {s2, s1, sig_in};
      if (state == IDLE && start) begin
        per_acc <= '0;
        high_acc <= '0;
        edge_cnt <= '0;
        timer <= '0;
        err_timeout <= 1'b0;
      end
      if (busy) timer <= timer + TW'(1);
      if (state == ARM && rise && !tmo) begin
        per_acc <= CNT_W'(1);
        high_acc <= CNT_W'(1);
        edge_cnt <= '0;
      end
      if (state == MEASURE && !tmo && !last) begin
        edge_cnt <= edge_cnt + EW'(rise);
        per_acc <= per_acc + CNT_W'(per_acc != '1);
        high_acc <= high_acc + CNT_W'(s2 && high_acc != '1);
      end
      if (busy && state_nx == DONE) begin
        period_cnt <= per_acc;
        high_cnt <= high_acc;
        err_timeout <= tmo;
      end
    end
endmodule

// File: tb/tb_clk_div_meter.sv
// tb_clk_div_meter: checks clk_div_meter (16-bit and saturating 4-bit instances) against a range-sum model of the sampled input
module tb_clk_div_meter;
  localparam int NP = 4, TO = 1023;
  logic sys_clk = 0, sys_rst_n = 1, sig_in = 0, start = 0, meas_ready = 0;
  logic busy, meas_valid, err_timeout, busy_s, meas_valid_s, err_timeout_s;
  logic [15:0] period_cnt, high_cnt;
  logic [3:0] period_cnt_s, high_cnt_s;
  int total = 0, bad = 0;
  int pat_len = 5, pat_hi = 3, ph = 0;
  clk_div_meter #(.N_PERIODS(NP), .CNT_W(16), .TIMEOUT(TO)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .sig_in(sig_in), .start(start),
    .busy(busy), .meas_valid(meas_valid), .meas_ready(meas_ready),
    .period_cnt(period_cnt), .high_cnt(high_cnt), .err_timeout(err_timeout));
  clk_div_meter #(.N_PERIODS(NP), .CNT_W(4), .TIMEOUT(TO)) dut_s (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .sig_in(sig_in), .start(start),
    .busy(busy_s), .meas_valid(meas_valid_s), .meas_ready(meas_ready),
    .period_cnt(period_cnt_s), .high_cnt(high_cnt_s), .err_timeout(err_timeout_s));
  always #5 sys_clk = ~sys_clk;
  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d at %0t", n, a, e, $time);
    end
  endtask
  initial forever begin
    @(negedge sys_clk);
    sig_in = ph < pat_hi;
    ph = (ph + 1) % pat_len;
  end
  task automatic set_pat(int len, int hi);
    pat_len = len;
    pat_hi = hi;
    ph = 0;
  endtask
  bit vh [0:65535];
  int cyc = 0, base = 0, js = 0;
  int rises[$];
  bit m_busy = 0, e_busy = 0, e_valid = 0, e_err = 0;
  int e_per = 0, e_high = 0, e_sper = 0, e_shigh = 0;
  function automatic bit vv(int k);
    return (k < base || k < 0) ? 1'b0 : vh[k];
  endfunction
  function automatic int sat(int x, int w);
    return x > (1 << w) - 1 ? (1 << w) - 1 : x;
  endfunction
  task automatic close_meas(bit to, int j);
    int f = rises.size() > 0 ? rises[0] : j;
    int h = 0;
    for (int k = f; k < j; k++) h += int'(vv(k - 2));
    e_per = sat(j - f, 16);
    e_high = sat(h, 16);
    e_sper = sat(j - f, 4);
    e_shigh = sat(h, 4);
    e_err = to;
    e_valid = 1;
    m_busy = 0;
  endtask
  initial forever begin
    @(posedge sys_clk or negedge sys_rst_n);
    if (!sys_rst_n) begin
      m_busy = 0; e_busy = 0; e_valid = 0; e_err = 0;
      e_per = 0; e_high = 0; e_sper = 0; e_shigh = 0;
      base = cyc;
      rises.delete();
    end else begin
      vh[cyc] = sig_in;
      if (e_valid) e_valid = !meas_ready;
      else if (m_busy) begin
        if (cyc - js == TO) close_meas(1, cyc);
        else if (vv(cyc - 2) && !vv(cyc - 3)) begin
          rises.push_back(cyc);
          if (rises.size() == NP + 1) close_meas(0, cyc);
        end
      end else if (start) begin
        m_busy = 1;
        js = cyc;
        rises.delete();
        e_err = 0;
      end
      e_busy = m_busy;
      cyc++;
    end
  end
  initial forever begin
    @(negedge sys_clk);
    chk("cyc_busy", busy, e_busy);
    chk("cyc_valid", meas_valid, e_valid);
    chk("cyc_per", period_cnt, e_per);
    chk("cyc_high", high_cnt, e_high);
    chk("cyc_err", err_timeout, e_err);
    chk("cyc_s_busy", busy_s, e_busy);
    chk("cyc_s_valid", meas_valid_s, e_valid);
    chk("cyc_s_per", period_cnt_s, e_sper);
    chk("cyc_s_high", high_cnt_s, e_shigh);
    chk("cyc_s_err", err_timeout_s, e_err);
  end
  task automatic pulse_start();
    @(negedge sys_clk) start = 1;
    @(negedge sys_clk) start = 0;
  endtask
  task automatic run(int lim);
    int n = 0;
    pulse_start();
    while (!meas_valid && n < lim) begin
      @(negedge sys_clk);
      n++;
    end
    chk("wait_valid", meas_valid, 1);
  endtask
  task automatic res(string n, int p, int h, int e, int sp, int sh);
    chk({n, "_per"}, period_cnt, p);
    chk({n, "_high"}, high_cnt, h);
    chk({n, "_err"}, err_timeout, e);
    chk({n, "_s_per"}, period_cnt_s, sp);
    chk({n, "_s_high"}, high_cnt_s, sh);
  endtask
  task automatic ack();
    meas_ready = 1;
    @(negedge sys_clk) meas_ready = 0;
    chk("ack_valid", meas_valid, 0);
    chk("ack_busy", busy, 0);
  endtask
  task automatic zeros(string n);
    chk({n, "_busy"}, busy, 0);
    chk({n, "_valid"}, meas_valid, 0);
    chk({n, "_per"}, period_cnt, 0);
    chk({n, "_high"}, high_cnt, 0);
    chk({n, "_err"}, err_timeout, 0);
    chk({n, "_s_per"}, period_cnt_s, 0);
  endtask
  initial begin
    int n, cnt;
    #1 sys_rst_n = 0;
    repeat (3) @(negedge sys_clk);
    zeros("rst");
    sys_rst_n = 1;
    set_pat(5, 3);
    repeat (8) @(negedge sys_clk);
    run(200);
    res("div5", 20, 12, 0, 15, 12);
    ack();
    set_pat(3, 2);
    repeat (6) @(negedge sys_clk);
    run(200);
    res("div3", 12, 8, 0, 12, 8);
    ack();
    chk("idle_keep_per", period_cnt, 12);
    set_pat(5, 3);
    repeat (6) @(negedge sys_clk);
    pulse_start();
    repeat (14) @(negedge sys_clk);
    chk("mid_busy", busy, 1);
    #2 sys_rst_n = 0;
    #1 zeros("async_rst");
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1;
    repeat (6) @(negedge sys_clk);
    run(200);
    res("div5_again", 20, 12, 0, 15, 12);
    ack();
    set_pat(1, 0);
    repeat (6) @(negedge sys_clk);
    pulse_start();
    n = 0;
    cnt = 0;
    while (!meas_valid && n < 2000) begin
      if (busy) cnt++;
      @(negedge sys_clk);
      n++;
    end
    chk("to_busy_cycles", cnt, TO);
    chk("to_valid", meas_valid, 1);
    res("stuck0", 0, 0, 1, 0, 0);
    ack();
    set_pat(1, 1);
    repeat (6) @(negedge sys_clk);
    run(1200);
    res("stuck1", 0, 0, 1, 0, 0);
    ack();
    set_pat(10, 5);
    repeat (6) @(negedge sys_clk);
    run(200);
    res("p10", 40, 20, 0, 15, 15);
    for (int i = 0; i < 10; i++) begin
      start = (i % 3 == 0);
      @(negedge sys_clk);
      chk("bp_valid", meas_valid, 1);
      res("bp", 40, 20, 0, 15, 15);
    end
    start = 1;
    meas_ready = 1;
    @(negedge sys_clk);
    start = 0;
    meas_ready = 0;
    chk("bp_rel_valid", meas_valid, 0);
    chk("bp_rel_busy", busy, 0);
    repeat (2) @(negedge sys_clk);
    chk("bp_start_dropped", busy, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #1000000;
    bad++;
    $display("FAIL watchdog got=timeout want=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
